imem_loader: RTL and testbench
==============================

Name: imem_loader

Overview:
Writer side of the instruction memory. It receives a byte stream from a UART RX or debug byte source and turns it into 32-bit instruction words. It writes those words sequentially into the instruction RAM that the RV32I core fetches from with word index addr[31:2]. It holds the CPU while a load is in progress and reports whether the load completed or failed.

Parameters:
- ADDR_WIDTH, 8, word-address width of the instruction memory (depth 2**ADDR_WIDTH = 256 words)
- TIMEOUT_CYCLES, 1_000_000, idle clocks allowed between bytes during a load before it is aborted

Ports:
- clk  input  1  system clock, all state on rising edge
- reset  input  1  asynchronous, active-high reset
- rx_data  input  8  incoming byte
- rx_valid  input  1  one-cycle strobe; rx_data is valid in that cycle
- mem_we  output  1  instruction-memory write enable, one-cycle pulse per word
- mem_waddr  output  32  byte address of the word (word_index << 2)
- mem_wdata  output  32  assembled instruction word
- cpu_hold  output  1  high while memory contents are incomplete or invalid; the core must be stalled or held in reset
- load_done  output  1  level; last load completed with a good checksum
- load_error  output  1  level; last load aborted (bad length, timeout, checksum)
- words_written  output  ADDR_WIDTH+1  words written in the current or last load

Behaviour:
- Frame format: MAGIC 0xA5, LEN_LO, LEN_HI (word count N, little-endian), N×4 data bytes with each word little-endian (first byte = bits 7:0), then CSUM = XOR of all data bytes.
- States:
  - IDLE: 0xA5 → LEN_LO; any other byte is ignored.
  - LEN_LO: latch the low byte → LEN_HI.
  - LEN_HI: latch the high byte; if N==0 or N>2**ADDR_WIDTH → ERROR, else → DATA.
  - DATA: collect bytes; after the 4th byte of the last word → CHECK.
  - CHECK: next byte compared with the running XOR; equal → DONE, else → ERROR.
  - DONE / ERROR: 0xA5 → LEN_LO (restart); any other byte is ignored.
- Reset values: state IDLE, all outputs 0, byte/word counters 0, checksum 0.
- Timing and outputs:
  - Writes: mem_we pulses exactly one clock after the rx_valid cycle carrying byte 3 of a word. mem_waddr and mem_wdata are registered and valid in that same cycle. mem_we is 0 at all other times.
  - Word index: starts at 0 for every frame and increments after each write. It cannot wrap because of the length check.
  - words_written: cleared on MAGIC, incremented together with mem_we.
  - cpu_hold: set one clock after MAGIC is accepted. Stays 1 through DATA and CHECK, and stays 1 in ERROR because memory may be partially overwritten. Cleared on entry to DONE. It is 0 after reset, so the core runs the existing memory contents.
  - load_done / load_error: both cleared on MAGIC. Each is set on entry to DONE or ERROR respectively and is a level that holds until the next MAGIC or reset.
- Timeout: a counter runs in LEN_LO, LEN_HI, DATA and CHECK, and is cleared on every rx_valid. When it reaches TIMEOUT_CYCLES-1 the block goes to ERROR. If a byte arrives in the same cycle the timeout would fire, the byte wins and the counter clears. The counter is not running in IDLE, DONE or ERROR.
- A partial word left in the assembler at an abort is discarded, not written.
- Reset mid-load: everything returns to reset values immediately; a partially written memory is not rolled back.
- rx_valid is assumed to be a single-cycle strobe; back-to-back bytes on consecutive clocks must be accepted.

Decomposition:
- Package imem_loader_pkg:
  - state enum (IDLE, LEN_LO, LEN_HI, DATA, CHECK, DONE, ERROR)
  - localparam MAGIC = 8'hA5
  - localparam BYTES_PER_WORD = 4
- Sub-module loader_timeout: counter with clear and enable inputs and an expired output, parameterised by TIMEOUT_CYCLES. The FSM, byte assembler and checksum stay in the top module.

Test Plan:
- Good 2-word load: bytes A5 02 00 13 02 11 00 B3 00 21 40 D2 on consecutive clocks → two writes:
  - mem_we @addr 0x0 data 0x00110213
  - mem_we @addr 0x4 data 0x402100B3
  - then words_written=2, load_done=1, cpu_hold=0.
- Bad checksum: the same frame with CSUM 0xD3 → both writes still occur, then load_error=1, cpu_hold stays 1, load_done=0.
- Length errors: A5 00 00 → ERROR with no write; A5 01 01 (N=257) → ERROR with no write.
- Timeout: A5 01 00 13 02, then silence (use TIMEOUT_CYCLES=16) → load_error=1 after 16 clocks, no mem_we; then send a full good frame → load_done=1, load_error=0.
- Noise and restart:
  - bytes 00 FF 13 while in IDLE → no state change, cpu_hold=0.
  - 0xA5 while in DONE → load_done=0, cpu_hold=1, words_written=0.
- Reset mid-load: assert reset after the 6th data byte → all outputs 0 and state IDLE at once; a new good frame loads correctly starting at address 0.

Source files
------------

// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory loader.
package imem_loader_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN_LO,
        S_LEN_HI,
        S_DATA,
        S_CHECK,
        S_DONE,
        S_ERROR
    } state_t;

    localparam logic [7:0]  MAGIC          = 8'hA5;
    localparam int unsigned BYTES_PER_WORD = 4;

endpackage

// File: rtl/imem_loader_timeout.sv
// Inter-byte idle counter for the loader; flags when a load has stalled too long.
module loader_timeout #(
    parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic clear_i,
    input  logic enable_i,
    output logic expired_o
);

    localparam int unsigned   CW    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] cnt_q;

    // Count idle clocks while enabled; a byte or leaving the active states restarts from zero
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (clear_i || !enable_i) begin
            cnt_q <= '0;
        end else if (cnt_q != LIMIT) begin
            cnt_q <= cnt_q + CW'(1);
        end
    end

    assign expired_o = enable_i && (cnt_q == LIMIT);

endmodule

// File: rtl/imem_loader.sv
// Byte-stream frame loader: assembles little-endian words and writes them
// sequentially into the instruction RAM, holding the CPU while a load is open.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH     = 8,
    parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [7:0]            rx_data,
    input  logic                  rx_valid,
    output logic                  mem_we,
    output logic [31:0]           mem_waddr,
    output logic [31:0]           mem_wdata,
    output logic                  cpu_hold,
    output logic                  load_done,
    output logic                  load_error,
    output logic [ADDR_WIDTH:0]   words_written
);

    localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

    state_t              state_q;
    logic [15:0]         len_q;
    logic [1:0]          byte_cnt_q;
    logic [23:0]         asm_q;
    logic [7:0]          csum_q;
    logic [ADDR_WIDTH:0] words_q;
    logic                mem_we_q;
    logic [31:0]         mem_waddr_q;
    logic [31:0]         mem_wdata_q;
    logic                cpu_hold_q;
    logic                done_q;
    logic                err_q;

    logic                active;
    logic                expired;
    logic [15:0]         len_full;
    logic [ADDR_WIDTH:0] words_inc;

    assign active    = (state_q == S_LEN_LO) || (state_q == S_LEN_HI) ||
                       (state_q == S_DATA)   || (state_q == S_CHECK);
    assign len_full  = {rx_data, len_q[7:0]};
    assign words_inc = words_q + 1'b1;

    loader_timeout #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk      (clk),
        .rst      (reset),
        .clear_i  (rx_valid),
        .enable_i (active),
        .expired_o(expired)
    );

    // Frame parser, word assembler, checksum and registered status outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            len_q       <= '0;
            byte_cnt_q  <= '0;
            asm_q       <= '0;
            csum_q      <= '0;
            words_q     <= '0;
            mem_we_q    <= 1'b0;
            mem_waddr_q <= '0;
            mem_wdata_q <= '0;
            cpu_hold_q  <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            mem_we_q <= 1'b0;
            // Idle/terminal states only react to MAGIC; active states either
            // consume a byte or, when no byte arrives, may time out.
            if (!active) begin
                if (rx_valid && rx_data == MAGIC) begin
                    state_q    <= S_LEN_LO;
                    cpu_hold_q <= 1'b1;
                    done_q     <= 1'b0;
                    err_q      <= 1'b0;
                    words_q    <= '0;
                    csum_q     <= '0;
                    byte_cnt_q <= '0;
                    len_q      <= '0;
                end
            end else if (!rx_valid) begin
                if (expired) begin
                    state_q <= S_ERROR;
                    err_q   <= 1'b1;
                end
            end else begin
                case (state_q)
                    S_LEN_LO: begin
                        len_q[7:0] <= rx_data;
                        state_q    <= S_LEN_HI;
                    end
                    S_LEN_HI: begin
                        len_q[15:8] <= rx_data;
                        if (len_full == 16'd0 || 32'(len_full) > DEPTH) begin
                            state_q <= S_ERROR;
                            err_q   <= 1'b1;
                        end else begin
                            state_q <= S_DATA;
                        end
                    end
                    S_DATA: begin
                        csum_q <= csum_q ^ rx_data;
                        if (byte_cnt_q == 2'(BYTES_PER_WORD - 1)) begin
                            mem_we_q    <= 1'b1;
                            mem_waddr_q <= 32'({words_q[ADDR_WIDTH-1:0], 2'b00});
                            mem_wdata_q <= {rx_data, asm_q};
                            words_q     <= words_inc;
                            byte_cnt_q  <= '0;
                            if (16'(words_inc) == len_q) begin
                                state_q <= S_CHECK;
                            end
                        end else begin
                            asm_q      <= {rx_data, asm_q[23:8]};
                            byte_cnt_q <= byte_cnt_q + 1'b1;
                        end
                    end
                    S_CHECK: begin
                        if (rx_data == csum_q) begin
                            state_q    <= S_DONE;
                            done_q     <= 1'b1;
                            cpu_hold_q <= 1'b0;
                        end else begin
                            state_q <= S_ERROR;
                            err_q   <= 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign mem_we        = mem_we_q;
    assign mem_waddr     = mem_waddr_q;
    assign mem_wdata     = mem_wdata_q;
    assign cpu_hold      = cpu_hold_q;
    assign load_done     = done_q;
    assign load_error    = err_q;
    assign words_written = words_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed and randomized frames checked against a frame-level expectation model.
module tb_imem_loader;

    localparam int unsigned AW = 8;
    localparam int unsigned TO = 16;

    logic          clk = 1'b0;
    logic          reset;
    logic [7:0]    rx_data;
    logic          rx_valid;
    logic          mem_we;
    logic [31:0]   mem_waddr;
    logic [31:0]   mem_wdata;
    logic          cpu_hold;
    logic          load_done;
    logic          load_error;
    logic [AW:0]   words_written;

    imem_loader #(
        .ADDR_WIDTH    (AW),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .mem_we       (mem_we),
        .mem_waddr    (mem_waddr),
        .mem_wdata    (mem_wdata),
        .cpu_hold     (cpu_hold),
        .load_done    (load_done),
        .load_error   (load_error),
        .words_written(words_written)
    );

    always #5 clk = ~clk;

    int vectors    = 0;
    int miscompares = 0;
    int we_count   = 0;

    logic [7:0]  frame[$];
    logic [31:0] words[$];

    // Count every write pulse the DUT emits, independent of the per-byte checks
    always @(posedge clk) begin
        #1;
        if (mem_we === 1'b1) we_count++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Drive one byte for exactly one clock; returns at the following negedge
    task automatic put(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    // Frame = MAGIC, length, optional body from words[], checksum (optionally corrupted)
    function automatic void build_frame(input logic [15:0] len, input bit with_body,
                                        input logic [7:0] csum_flip);
        logic [7:0] cs;
        logic [31:0] w;
        cs = 8'h00;
        frame.delete();
        frame.push_back(8'hA5);
        frame.push_back(len[7:0]);
        frame.push_back(len[15:8]);
        if (with_body) begin
            foreach (words[i]) begin
                w = words[i];
                for (int k = 0; k < 4; k++) begin
                    frame.push_back(w[8*k +: 8]);
                    cs = cs ^ w[8*k +: 8];
                end
            end
            frame.push_back(cs ^ csum_flip);
        end
    endfunction

    function automatic void random_words(input int n);
        words.delete();
        for (int i = 0; i < n; i++) words.push_back($urandom);
    endfunction

    // Send the frame; n_ok words are expected to be written, one clock after each word's last byte
    task automatic run_stream(input int n_ok, input int max_gap);
        int start;
        int w;
        start = we_count;
        for (int i = 0; i < frame.size(); i++) begin
            put(frame[i]);
            if (i == 0) begin
                check("hold_after_magic", 32'(cpu_hold), 32'd1);
                check("done_clr_magic",   32'(load_done), 32'd0);
                check("err_clr_magic",    32'(load_error), 32'd0);
                check("ww_clr_magic",     32'(words_written), 32'd0);
            end
            if (i >= 3 && (i - 3) < 4 * n_ok && ((i - 3) % 4) == 3) begin
                w = (i - 3) / 4;
                check("we_pulse", 32'(mem_we), 32'd1);
                check("waddr", mem_waddr, 32'(w * 4));
                check("wdata", mem_wdata, words[w]);
            end else begin
                check("we_quiet", 32'(mem_we), 32'd0);
            end
            repeat ($urandom_range(max_gap, 0)) @(negedge clk);
        end
        @(negedge clk);
        check("we_total", 32'(we_count - start), 32'(n_ok));
    endtask

    task automatic check_final(input bit done, input bit err, input bit hold, input int ww);
        check("load_done",     32'(load_done), 32'(done));
        check("load_error",    32'(load_error), 32'(err));
        check("cpu_hold",      32'(cpu_hold), 32'(hold));
        check("words_written", 32'(words_written), 32'(ww));
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_we"},    32'(mem_we), 32'd0);
        check({tag, "_waddr"}, mem_waddr, 32'd0);
        check({tag, "_wdata"}, mem_wdata, 32'd0);
        check({tag, "_hold"},  32'(cpu_hold), 32'd0);
        check({tag, "_done"},  32'(load_done), 32'd0);
        check({tag, "_err"},   32'(load_error), 32'd0);
        check({tag, "_ww"},    32'(words_written), 32'd0);
    endtask

    initial begin
        int cycles;
        int n;
        logic [7:0] flip;
        logic [7:0] noise[3];

        reset    = 1'b1;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        reset = 1'b0;
        @(negedge clk);

        // Noise in IDLE is ignored
        noise[0] = 8'h00; noise[1] = 8'hFF; noise[2] = 8'h13;
        for (int i = 0; i < 3; i++) begin
            put(noise[i]);
            check("idle_noise_hold", 32'(cpu_hold), 32'd0);
            check("idle_noise_we",   32'(mem_we), 32'd0);
        end
        check_final(1'b0, 1'b0, 1'b0, 0);

        // Reference two-word frame on consecutive clocks
        words.delete();
        words.push_back(32'h00110213);
        words.push_back(32'h402100B3);
        build_frame(16'd2, 1'b1, 8'h00);
        run_stream(2, 0);
        check_final(1'b1, 1'b0, 1'b0, 2);

        // Noise in DONE is ignored
        put(8'h00);
        check_final(1'b1, 1'b0, 1'b0, 2);

        // Same frame, checksum 0xD3
        build_frame(16'd2, 1'b1, 8'h01);
        run_stream(2, 0);
        check_final(1'b0, 1'b1, 1'b1, 2);

        // Length errors: zero and one past the memory depth
        build_frame(16'd0, 1'b0, 8'h00);
        run_stream(0, 0);
        check_final(1'b0, 1'b1, 1'b1, 0);
        build_frame(16'h0101, 1'b0, 8'h00);
        run_stream(0, 0);
        check_final(1'b0, 1'b1, 1'b1, 0);

        // Timeout with a partial word pending
        build_frame(16'd1, 1'b0, 8'h00);
        frame.push_back(8'h13);
        frame.push_back(8'h02);
        run_stream(0, 0);
        cycles = 1;
        while (load_error !== 1'b1 && cycles < 40) begin
            @(negedge clk);
            cycles++;
        end
        check("timeout_clocks", 32'(cycles), 32'(TO));
        check_final(1'b0, 1'b1, 1'b1, 0);
        random_words(1);
        build_frame(16'd1, 1'b1, 8'h00);
        run_stream(1, 0);
        check_final(1'b1, 1'b0, 1'b0, 1);

        // Reset after the sixth data byte
        random_words(2);
        build_frame(16'd2, 1'b1, 8'h00);
        for (int i = 0; i < 9; i++) put(frame[i]);
        reset = 1'b1;
        #1;
        check_all_zero("midreset");
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        random_words(3);
        build_frame(16'd3, 1'b1, 8'h00);
        run_stream(3, 0);
        check_final(1'b1, 1'b0, 1'b0, 3);

        // Largest legal frame fills the whole memory
        random_words(1 << AW);
        build_frame(16'(1 << AW), 1'b1, 8'h00);
        run_stream(1 << AW, 0);
        check_final(1'b1, 1'b0, 1'b0, 1 << AW);

        // Random frames with idle gaps shorter than the timeout
        for (int f = 0; f < 8; f++) begin
            n = $urandom_range(12, 1);
            flip = ($urandom_range(3, 0) == 0) ? 8'($urandom_range(255, 1)) : 8'h00;
            random_words(n);
            build_frame(16'(n), 1'b1, flip);
            run_stream(n, 5);
            check_final(flip == 8'h00, flip != 8'h00, flip != 8'h00, n);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
